// File: rtl/long_division_pkg.sv
// Shared types and constants for the AXI4-S long-division responder.
// Saturation limits are width dependent, so they are built by functions.
package long_division_pkg;

  typedef enum logic [2:0] {
    RX_DIVIDEND_E,
    RX_DIVISOR_E,
    DRAIN_E,
    DIVIDE_E,
    FINALISE_E,
    SEND_E
  } div_state_t;

  function automatic logic [63:0] sat_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/long_division_axi4s_if_if.sv
// AXI4-S beat bundle with master/slave views.
// One instance per direction of the divider.
interface long_division_axi4s_if_if #(
  parameter int W  = 32,
  parameter int ID = 4
);
  logic          tvalid;
  logic          tready;
  logic [W-1:0]  tdata;
  logic          tlast;
  logic [ID-1:0] tid;
  logic          tuser;

  modport master (
    output tvalid, tdata, tlast, tid, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tlast, tid, tuser,
    output tready
  );
endinterface

// File: rtl/long_division_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient
// bit per cycle, MSB first, fixed W+Q iterations.
module long_division_core #(
  parameter int W = 32,
  parameter int Q = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W+Q-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           done,
  output logic [W+Q-1:0] quotient
);
  localparam int QW = W + Q;
  localparam int CW = $clog2(QW);

  logic [QW-1:0] quo_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  div_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [W:0]    trial;
  logic          fits;

  assign trial    = {rem_q, quo_q[QW-1]};
  assign fits     = trial >= {1'b0, div_q};
  assign done     = busy_q && (cnt_q == CW'(QW - 1));
  assign quotient = quo_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      div_q  <= divisor;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      // remainder stays below the divisor, so W bits always hold it
      rem_q  <= fits ? W'(trial - {1'b0, div_q}) : W'(trial);
      quo_q  <= {quo_q[QW-2:0], fits};
      cnt_q  <= cnt_q + CW'(1);
      busy_q <= !done;
    end
  end
endmodule

// File: rtl/long_division_axi4s_if.sv
// AXI4-S responder: two-beat request in, signed Q-format quotient out.
// Holds the handshake FSM, sign handling and saturation.
module long_division_axi4s_if
  import long_division_pkg::*;
#(
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_ID_WIDTH_P   = 4,
  parameter int Q_BITS_P         = 15
) (
  input  logic clk,
  input  logic rst_n,
  long_division_axi4s_if_if.slave  ing,
  long_division_axi4s_if_if.master egr
);
  localparam int W  = AXI_DATA_WIDTH_P;
  localparam int ID = AXI_ID_WIDTH_P;
  localparam int Q  = Q_BITS_P;
  localparam int QW = W + Q;
  localparam logic [W-1:0] MAX_C = W'(sat_pos(W));
  localparam logic [W-1:0] MIN_C = W'(sat_neg(W));

  div_state_t    state, nxt;
  logic          ready_q, ready_nxt;
  logic [W-1:0]  n_q;
  logic [ID-1:0] id_q;
  logic          ns_q, ds_q, div0_q, err_q;
  logic          tv_q, tu_q;
  logic [W-1:0]  td_q;
  logic [ID-1:0] ti_q;

  logic          in_hs, start, done, neg;
  logic [W-1:0]  abs_n, abs_d, res_data;
  logic [QW-1:0] q;
  logic          res_user;

  assign in_hs = ing.tvalid && ready_q;
  assign start = (state == RX_DIVISOR_E) && in_hs && ing.tlast;
  assign abs_n = n_q[W-1] ? -n_q : n_q;
  assign abs_d = ing.tdata[W-1] ? -ing.tdata : ing.tdata;
  assign neg   = ns_q ^ ds_q;

  assign ing.tready = ready_q;
  assign egr.tvalid = tv_q;
  assign egr.tlast  = tv_q;
  assign egr.tdata  = td_q;
  assign egr.tid    = ti_q;
  assign egr.tuser  = tu_q;

  long_division_core #(.W(W), .Q(Q)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (QW'(abs_n) << Q),
    .divisor  (abs_d),
    .done     (done),
    .quotient (q)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      RX_DIVIDEND_E:
        if (in_hs) nxt = ing.tlast ? FINALISE_E : RX_DIVISOR_E;
      RX_DIVISOR_E:
        if (in_hs) nxt = ing.tlast ? DIVIDE_E : DRAIN_E;
      DRAIN_E:
        if (in_hs && ing.tlast) nxt = FINALISE_E;
      DIVIDE_E:
        if (done) nxt = FINALISE_E;
      FINALISE_E:
        nxt = SEND_E;
      SEND_E:
        if (egr.tready) nxt = RX_DIVIDEND_E;
      default:
        nxt = RX_DIVIDEND_E;
    endcase
    ready_nxt = (nxt == RX_DIVIDEND_E) ||
                (nxt == RX_DIVISOR_E) ||
                (nxt == DRAIN_E);
  end

  always_comb begin
    res_data = neg ? -q[W-1:0] : q[W-1:0];
    res_user = 1'b0;
    if (err_q) begin
      res_data = '0;
      res_user = 1'b1;
    end else if (div0_q) begin
      res_data = ns_q ? MIN_C : MAX_C;
      res_user = 1'b1;
    end else if (!neg && q > QW'(MAX_C)) begin
      res_data = MAX_C;
      res_user = 1'b1;
    end else if (neg && q > QW'(MIN_C)) begin
      res_data = MIN_C;
      res_user = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RX_DIVIDEND_E;
      ready_q <= 1'b0;
      n_q     <= '0;
      id_q    <= '0;
      ns_q    <= 1'b0;
      ds_q    <= 1'b0;
      div0_q  <= 1'b0;
      err_q   <= 1'b0;
      tv_q    <= 1'b0;
      td_q    <= '0;
      ti_q    <= '0;
      tu_q    <= 1'b0;
    end else begin
      state   <= nxt;
      ready_q <= ready_nxt;
      if (state == RX_DIVIDEND_E && in_hs) begin
        n_q   <= ing.tdata;
        ns_q  <= ing.tdata[W-1];
        id_q  <= ing.tid;
        err_q <= ing.tlast;
      end
      if (state == RX_DIVISOR_E && in_hs) begin
        ds_q   <= ing.tdata[W-1];
        div0_q <= ~|ing.tdata;
        err_q  <= ~ing.tlast;
      end
      if (state == FINALISE_E) begin
        tv_q <= 1'b1;
        td_q <= res_data;
        ti_q <= id_q;
        tu_q <= res_user;
      end
      if (state == SEND_E && egr.tready) tv_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_long_division_axi4s_if.sv
// Directed and random checks of the long-division responder against
// a plain-arithmetic fixed-point model.
module tb_long_division_axi4s_if;
  localparam int W   = 32;
  localparam int Q   = 15;
  localparam int LAT = W + Q + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   resp_hs = 0;

  long_division_axi4s_if_if #(.W(32), .ID(4)) ing_if ();
  long_division_axi4s_if_if #(.W(32), .ID(4)) egr_if ();

  long_division_axi4s_if #(
    .AXI_DATA_WIDTH_P (32),
    .AXI_ID_WIDTH_P   (4),
    .Q_BITS_P         (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ing   (ing_if),
    .egr   (egr_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int n, input int d,
                                output logic [31:0] q, output logic u);
    longint num, qq;
    if (d == 0) begin
      q = (n < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      u = 1'b1;
      return;
    end
    num = longint'(n) * (longint'(1) << Q);
    qq  = num / longint'(d);
    if (qq > 64'sd2147483647) begin
      q = 32'h7FFF_FFFF; u = 1'b1;
    end else if (qq < -64'sd2147483648) begin
      q = 32'h8000_0000; u = 1'b1;
    end else begin
      q = qq[31:0]; u = 1'b0;
    end
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic l,
                           input logic [3:0] id, output int hs);
    int  n = 0;
    bit  ok = 0;
    ing_if.tvalid = 1'b1;
    ing_if.tdata  = d;
    ing_if.tlast  = l;
    ing_if.tid    = id;
    while (!ok && n < 200) begin
      ok = ing_if.tready;
      @(posedge clk);
      n++;
    end
    #1;
    ing_if.tvalid = 1'b0;
    hs = cyc;
    if (!ok) chk("ing_timeout", 64'(ing_if.tready), 64'd1);
  endtask

  task automatic wait_valid(output int v);
    int n = 0;
    while (!egr_if.tvalid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    v = cyc;
    if (!egr_if.tvalid) chk("egr_timeout", 64'(egr_if.tvalid), 64'd1);
  endtask

  task automatic take;
    egr_if.tready = 1'b1;
    @(posedge clk); #1;
    egr_if.tready = 1'b0;
    resp_hs = cyc;
  endtask

  task automatic do_txn(input int n, input int d, input logic [3:0] id,
                        input string tag);
    int k, v, dmy;
    logic [31:0] eq;
    logic eu;
    send_beat(n, 1'b0, id, dmy);
    send_beat(d, 1'b1, ~id, k);
    wait_valid(v);
    model(n, d, eq, eu);
    chk({tag, "_data"}, 64'(egr_if.tdata), 64'(eq));
    chk({tag, "_user"}, 64'(egr_if.tuser), 64'(eu));
    chk({tag, "_tid"},  64'(egr_if.tid),   64'(id));
    chk({tag, "_last"}, 64'(egr_if.tlast), 64'd1);
    chk({tag, "_lat"},  64'(v - k),        64'(LAT));
    take();
  endtask

  initial begin
    int hs, v, bad, seen;
    int rn, rd;
    logic [31:0] sd;
    logic [3:0] si;
    logic su;
    ing_if.tvalid = 1'b0;
    ing_if.tdata  = '0;
    ing_if.tlast  = 1'b0;
    ing_if.tid    = '0;
    ing_if.tuser  = 1'b0;
    egr_if.tready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 64'(ing_if.tready), 64'd0);
    chk("rst_tvalid", 64'(egr_if.tvalid), 64'd0);
    chk("rst_tdata",  64'(egr_if.tdata),  64'd0);
    chk("rst_tuser",  64'(egr_if.tuser),  64'd0);
    chk("rst_tlast",  64'(egr_if.tlast),  64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready_rise", 64'(ing_if.tready), 64'd1);

    do_txn(327680, 131072, 4'd3, "basic");
    do_txn(-229376, 65536, 4'd5, "neg_pos");
    do_txn(-229376, -65536, 4'd6, "neg_neg");
    do_txn(32768, 0, 4'd7, "dz_pos");
    do_txn(-32768, 0, 4'd8, "dz_neg");
    do_txn(32'h4000_0000, 1, 4'd9, "ovf");
    do_txn(32'h8000_0000, 32768, 4'd10, "min_n");
    do_txn(32'h8000_0000, -32768, 4'd11, "min_ovf");

    // backpressure then back-to-back request
    send_beat(327680, 1'b0, 4'd12, hs);
    send_beat(-131072, 1'b1, 4'd0, hs);
    wait_valid(v);
    sd = egr_if.tdata;
    si = egr_if.tid;
    su = egr_if.tuser;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (egr_if.tdata !== sd || egr_if.tid !== si ||
          egr_if.tuser !== su || egr_if.tvalid !== 1'b1 ||
          ing_if.tready !== 1'b0) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    chk("bp_data", 64'(sd), 64'(32'hFFFE_C000));
    take();
    send_beat(98304, 1'b0, 4'd13, hs);
    chk("b2b_accept", 64'(hs - resp_hs), 64'd1);
    send_beat(32768, 1'b1, 4'd0, hs);
    wait_valid(v);
    chk("b2b_data", 64'(egr_if.tdata), 64'(32'h0001_8000));
    chk("b2b_tid",  64'(egr_if.tid),   64'd13);
    take();

    // single beat carrying tlast
    send_beat(327680, 1'b1, 4'd2, hs);
    wait_valid(v);
    chk("one_data", 64'(egr_if.tdata), 64'd0);
    chk("one_user", 64'(egr_if.tuser), 64'd1);
    chk("one_tid",  64'(egr_if.tid),   64'd2);
    take();

    // three-beat request is drained
    send_beat(327680, 1'b0, 4'd4, hs);
    send_beat(131072, 1'b0, 4'd0, hs);
    send_beat(5, 1'b1, 4'd0, hs);
    wait_valid(v);
    chk("three_data", 64'(egr_if.tdata), 64'd0);
    chk("three_user", 64'(egr_if.tuser), 64'd1);
    chk("three_tid",  64'(egr_if.tid),   64'd4);
    take();
    @(posedge clk); #1;
    chk("three_single", 64'(egr_if.tvalid), 64'd0);

    // reset while dividing aborts silently
    send_beat(327680, 1'b0, 4'd1, hs);
    send_beat(131072, 1'b1, 4'd0, hs);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (LAT + 10) begin
      @(posedge clk); #1;
      if (egr_if.tvalid) seen++;
    end
    chk("abort_no_resp", 64'(seen), 64'd0);
    do_txn(-327680, 131072, 4'd14, "after_rst");

    for (int i = 0; i < 16; i++) begin
      rn = int'($urandom) >>> $urandom_range(0, 31);
      rd = int'($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) rd = -rd;
      do_txn(rn, rd, 4'($urandom_range(0, 15)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
